arm_fetch_queue: RTL and testbench

ARM_FETCH_QUEUE -- requirements
Module: arm_fetch_queue

---
 rtl/arm_fetch_queue.sv | 105 ++++++++++
 tb/tb_arm_fetch_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/arm_fetch_queue.sv
// arm_fetch_queue: single-outstanding instruction fetcher feeding a FIFO prefetch queue
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req/imem_addr           word fetch request, held stable until imem_ack
//   imem_ack/imem_rdata          request completion and fetched word
//   redirect_valid/redirect_addr flush queue and restart fetch at a new word address
//   halt                         stop issuing fetches; halted reports the sticky stop
//   inst_valid/inst_data/inst_pc queue head; popped when inst_ready is high
//   fifo_count                   number of valid queue entries
module arm_fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 30,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_addr,
   input  logic                       halt,
   output logic                       inst_valid,
   output logic [31:0]                inst_data,
   output logic [ADDR_W-1:0]          inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       halted
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD, HALTED} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
   logic              halt_q;
   logic [CW-1:0]     count_q, count_d;
   logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [31:0]       data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem [DEPTH];
   logic              redir, halting, push, pop;
   // Once halted the fetcher is frozen, so redirects no longer flush or retarget.
   assign redir   = redirect_valid && state_q != HALTED;
   assign halting = halt || halt_q;
   assign push    = imem_ack && state_q == WAIT && !redir;
   assign pop     = inst_valid && inst_ready && !redir;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            pc_d    = redir ? redirect_addr : pc_q;
            state_d = halting ? HALTED : (redir || count_q < CW'(DEPTH)) ? WAIT : IDLE;
         end
         WAIT: begin
            pc_d    = imem_ack ? (redir ? redirect_addr : pc_q + 1'b1) : pc_q;
            tgt_d   = redir ? redirect_addr : tgt_q;
            state_d = imem_ack ? (halting ? HALTED : IDLE) : redir ? WAIT_DISCARD : WAIT;
         end
         WAIT_DISCARD: begin
            // imem_addr must hold for the dropped request, so the target waits in tgt_q.
            tgt_d   = redir ? redirect_addr : tgt_q;
            pc_d    = imem_ack ? tgt_d : pc_q;
            state_d = imem_ack ? (halting ? HALTED : IDLE) : WAIT_DISCARD;
         end
         default: state_d = HALTED;
      endcase
   end
   assign count_d = redir ? '0 : count_q + CW'(push) - CW'(pop);
   assign rd_d    = redir ? '0 : rd_q + AW'(pop);
   assign wr_d    = redir ? '0 : wr_q + AW'(push);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
         halt_q  <= 1'b0;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         halt_q  <= halting;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_q] <= imem_rdata;
         pc_mem[wr_q]   <= pc_q;
      end
   end
   assign imem_req   = state_q == WAIT || state_q == WAIT_DISCARD;
   assign imem_addr  = pc_q;
   assign inst_valid = count_q != '0;
   assign inst_data  = data_mem[rd_q];
   assign inst_pc    = pc_mem[rd_q];
   assign fifo_count = count_q;
   assign halted     = state_q == HALTED;
endmodule

// File: tb/tb_arm_fetch_queue.sv
// tb_arm_fetch_queue: directed vector bench for arm_fetch_queue
module tb_arm_fetch_queue;
   logic        clk = 0, rst = 1;
   logic        imem_req, imem_ack = 0, redirect_valid = 0, halt = 0, inst_valid, inst_ready = 1, halted;
   logic [29:0] imem_addr, redirect_addr = '0, inst_pc;
   logic [31:0] imem_rdata = '0, inst_data;
   logic [2:0]  fifo_count;
   logic        w_req, w_valid, w_halted;
   logic [3:0]  w_addr, w_pc;
   logic [31:0] w_data;
   logic [2:0]  w_count;
   logic [3:0]  wseen [4];
   logic [3:0]  wexp [4];
   int          wn = 0;
   int          errors = 0, checks = 0;
   always #5 clk = ~clk;
   typedef struct {
      logic ack, ready, redir; logic [29:0] raddr; logic halt;
      logic req; logic [29:0] addr; logic valid; logic [29:0] pc; logic [2:0] cnt; logic halted;
   } vec_t;
   vec_t tab [19];
   arm_fetch_queue #(.DEPTH(4), .ADDR_W(30), .RESET_PC(30'd0)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .halt(halt), .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .fifo_count(fifo_count), .halted(halted));
   arm_fetch_queue #(.DEPTH(4), .ADDR_W(4), .RESET_PC(4'd14)) wdut (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req),
      .imem_rdata(32'd0), .redirect_valid(1'b0), .redirect_addr(4'd0),
      .halt(1'b0), .inst_valid(w_valid), .inst_data(w_data), .inst_pc(w_pc),
      .inst_ready(1'b1), .fifo_count(w_count), .halted(w_halted));
   always @(posedge clk) if (!rst && w_req && wn < 4) begin
      wseen[wn] <= w_addr;
      wn <= wn + 1;
   end
   function automatic logic [31:0] dfun(input logic [29:0] a);
      return {2'b10, a} ^ 32'h1234_5678;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic step(input vec_t v);
      chk("imem_req", 32'(imem_req), 32'(v.req));
      chk("imem_addr", 32'(imem_addr), 32'(v.addr));
      chk("inst_valid", 32'(inst_valid), 32'(v.valid));
      if (v.valid) begin
         chk("inst_pc", 32'(inst_pc), 32'(v.pc));
         chk("inst_data", inst_data, dfun(v.pc));
      end
      chk("fifo_count", 32'(fifo_count), 32'(v.cnt));
      chk("halted", 32'(halted), 32'(v.halted));
      imem_ack = v.ack; imem_rdata = dfun(v.addr); inst_ready = v.ready;
      redirect_valid = v.redir; redirect_addr = v.raddr; halt = v.halt;
      @(negedge clk);
   endtask
   task automatic hs(input logic ack, ready, redir, input logic [29:0] raddr, input logic hlt,
                     input logic req, input logic [29:0] addr, input logic valid,
                     input logic [29:0] pc, input logic [2:0] cnt, input logic hd);
      vec_t v;
      v = '{ack, ready, redir, raddr, hlt, req, addr, valid, pc, cnt, hd};
      step(v);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1; imem_ack = 1;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 0; imem_ack = 0; redirect_valid = 0; halt = 0; inst_ready = 1;
   endtask
   initial begin
      wexp = '{4'd14, 4'd15, 4'd0, 4'd1};
      tab = '{
         '{0,1,0,0,0, 0,0,0,0,0,0}, '{1,1,0,0,0, 1,0,0,0,0,0}, '{0,1,0,0,0, 0,1,1,0,1,0},
         '{1,1,0,0,0, 1,1,0,0,0,0}, '{0,1,0,0,0, 0,2,1,1,1,0}, '{1,1,0,0,0, 1,2,0,0,0,0},
         '{0,1,0,0,0, 0,3,1,2,1,0}, '{1,1,0,0,0, 1,3,0,0,0,0}, '{0,0,0,0,0, 0,4,1,3,1,0},
         '{1,0,0,0,0, 1,4,1,3,1,0}, '{0,0,0,0,0, 0,5,1,3,2,0}, '{1,0,0,0,0, 1,5,1,3,2,0},
         '{0,0,0,0,0, 0,6,1,3,3,0}, '{1,0,0,0,0, 1,6,1,3,3,0}, '{1,0,0,0,0, 0,7,1,3,4,0},
         '{0,1,0,0,0, 0,7,1,3,4,0}, '{0,0,0,0,0, 0,7,1,4,3,0}, '{1,0,0,0,0, 1,7,1,4,3,0},
         '{0,0,0,0,0, 0,8,1,4,4,0}};
      do_reset();
      for (int i = 0; i < 19; i++) step(tab[i]);
      chk("wrap_fetches", 32'(wn), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), 32'(wseen[i]), 32'(wexp[i]));
      // redirect while a request is outstanding, retargeted twice before the discarded ack
      do_reset();
      hs(0,1,1,30'h5,  0, 0,30'h0,  0,0,0,0);
      hs(0,1,1,30'h100,0, 1,30'h5,  0,0,0,0);
      hs(0,1,1,30'h200,0, 1,30'h5,  0,0,0,0);
      hs(0,1,1,30'h100,0, 1,30'h5,  0,0,0,0);
      hs(1,1,0,30'h0,  0, 1,30'h5,  0,0,0,0);
      hs(0,1,0,30'h0,  0, 0,30'h100,0,0,0,0);
      hs(1,1,0,30'h0,  0, 1,30'h100,0,0,0,0);
      hs(0,1,0,30'h0,  0, 0,30'h101,1,30'h100,1,0);
      hs(1,0,0,30'h0,  0, 1,30'h101,0,0,0,0);
      hs(0,0,0,30'h0,  0, 0,30'h102,1,30'h101,1,0);
      // redirect in the ack cycle with a pop pending
      hs(1,1,1,30'h300,0, 1,30'h102,1,30'h101,1,0);
      hs(0,1,0,30'h0,  0, 0,30'h300,0,0,0,0);
      hs(0,1,0,30'h0,  0, 1,30'h300,0,0,0,0);
      // halt during an outstanding request
      do_reset();
      hs(0,0,0,30'h0, 0, 0,30'h0,0,0,0,0);
      hs(0,0,0,30'h0, 1, 1,30'h0,0,0,0,0);
      hs(1,0,0,30'h0, 0, 1,30'h0,0,0,0,0);
      hs(0,0,1,30'h50,0, 0,30'h1,1,30'h0,1,1);
      hs(0,1,0,30'h0, 0, 0,30'h1,1,30'h0,1,1);
      hs(1,1,0,30'h0, 0, 0,30'h1,0,0,0,1);
      hs(0,1,0,30'h0, 0, 0,30'h1,0,0,0,1);
      // reset asserted mid-request
      do_reset();
      hs(0,1,0,30'h0, 0, 0,30'h0,0,0,0,0);
      hs(0,1,0,30'h0, 0, 1,30'h0,0,0,0,0);
      do_reset();
      hs(0,1,0,30'h0, 0, 0,30'h0,0,0,0,0);
      hs(0,1,0,30'h0, 0, 1,30'h0,0,0,0,0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
